sprite_capture: RTL and testbench

Inverse of the 16x16 sprite renderer. It deserializes a 1-bit pixel stream, either the renderer gfx output or any on-screen region, into 16 rows of 16 bits. Each row is written out as two bytes in exactly the tank-bitmap ROM layout: address {bitmap, row, half}, low byte = pixels 0..7. The block sits beside the hvsync generator and feeds a writable bitmap RAM. Uses: sprite self-test readback and runtime bitmap generation.

---
 rtl/sprite_pkg.sv | 33 +++
 rtl/sprite_capture_if.sv | 31 +++
 rtl/sprite_capture.sv | 169 ++++++++++++++++
 tb/tb_sprite_capture.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// Shared constants and types for the 16x16 sprite renderer and the sprite capture block.
// The bitmap RAM address is {bitmap, row, half}; the low byte of a row holds pixels 0..7.
package sprite_pkg;

  localparam int unsigned SPRITE_W      = 16;
  localparam int unsigned SPRITE_H      = 16;
  localparam int unsigned BYTES_PER_ROW = 2;

  localparam int unsigned BM_W   = 3;
  localparam int unsigned ROW_W  = 4;
  localparam int unsigned HALF_W = 1;
  localparam int unsigned ADDR_W = BM_W + ROW_W + HALF_W;
  localparam int unsigned DATA_W = SPRITE_W / BYTES_PER_ROW;
  localparam int unsigned XCNT_W = $clog2(SPRITE_W);

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    WAIT_VSTART = 3'd1,
    WAIT_HSTART = 3'd2,
    DELAY       = 3'd3,
    CAPTURE     = 3'd4,
    STORE_LO    = 3'd5,
    STORE_HI    = 3'd6,
    FINISH      = 3'd7
  } cap_state_e;

  typedef struct packed {
    logic [BM_W-1:0]   bitmap;
    logic [ROW_W-1:0]  row;
    logic [HALF_W-1:0] half;
  } bm_addr_t;

endpackage

// File: rtl/sprite_capture_if.sv
// Capture control, video timing, pixel stream and bitmap RAM write port.
// slave  : the capture block (consumes control/timing/pixel, drives the RAM write port)
// master : the environment (video timing, pixel source, bitmap RAM)
interface sprite_capture_if;
  import sprite_pkg::*;

  logic              arm;
  logic [BM_W-1:0]   bitmap_num;
  logic              hmirror;
  logic              vmirror;
  logic              abort;
  logic              vstart;
  logic              hstart;
  logic              pixel;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_en;
  logic              busy;
  logic              done;

  modport slave (
    input  arm, bitmap_num, hmirror, vmirror, abort, vstart, hstart, pixel,
    output wr_addr, wr_data, wr_en, busy, done
  );

  modport master (
    output arm, bitmap_num, hmirror, vmirror, abort, vstart, hstart, pixel,
    input  wr_addr, wr_data, wr_en, busy, done
  );

endinterface

// File: rtl/sprite_capture.sv
// Deserializes a 1-bit pixel stream into ROWS rows of 16 pixels and writes each row
// as two bytes into a bitmap RAM in the tank-bitmap ROM layout.
// Ports:
//   clk   : pixel clock
//   reset : asynchronous active-low reset
//   cap   : control (arm/abort/config), timing (vstart/hstart), pixel in,
//           RAM write port (wr_addr/wr_data/wr_en), status (busy/done); all outputs registered
module sprite_capture
  import sprite_pkg::*;
#(
  parameter int unsigned SAMPLE_DELAY = 1,   // 0..255
  parameter int unsigned ROWS         = 16   // 1..16
) (
  input  logic            clk,
  input  logic            reset,
  sprite_capture_if.slave cap
);

  localparam int unsigned DCNT_W = 8;

  cap_state_e          r_state;
  cap_state_e          w_next;
  logic [BM_W-1:0]     r_bm;
  logic                r_hm;
  logic                r_vm;
  logic [ROW_W-1:0]    r_ycount;
  logic [XCNT_W-1:0]   r_xcount;
  logic [XCNT_W-1:0]   w_xidx;
  logic [DCNT_W-1:0]   r_dcount;
  logic [SPRITE_W-1:0] r_inbits;
  logic [SPRITE_W-1:0] w_inbits;
  logic                w_accept;
  bm_addr_t            w_addr;

  logic                w_wr_en;
  logic                w_done;
  logic [ADDR_W-1:0]   w_wr_addr;
  logic [DATA_W-1:0]   w_wr_data;

  logic                r_wr_en;
  logic                r_done;
  logic                r_busy;
  logic [ADDR_W-1:0]   r_wr_addr;
  logic [DATA_W-1:0]   r_wr_data;

  assign w_accept = (r_state == IDLE) && cap.arm && !cap.abort;
  assign w_xidx   = r_hm ? ~r_xcount : r_xcount;

  // Shift register with the current sample merged in, so the low byte can be
  // registered on the same edge that takes the last pixel.
  always_comb begin
    w_inbits = r_inbits;
    if (r_state == CAPTURE) begin
      w_inbits[w_xidx] = cap.pixel;
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state and next output values (outputs follow the state being entered)
  always_comb begin
    w_next      = r_state;
    w_wr_en     = 1'b0;
    w_done      = 1'b0;
    w_wr_addr   = r_wr_addr;
    w_wr_data   = r_wr_data;
    w_addr.bitmap = r_bm;
    w_addr.row    = r_vm ? ~r_ycount : r_ycount;
    w_addr.half   = 1'b0;

    if (cap.abort && (r_state != IDLE)) begin
      w_next = IDLE;
    end else begin
      case (r_state)
        IDLE:        if (w_accept) w_next = WAIT_VSTART;
        WAIT_VSTART: if (cap.vstart) w_next = WAIT_HSTART;
        WAIT_HSTART: if (cap.hstart) w_next = (SAMPLE_DELAY > 0) ? DELAY : CAPTURE;
        DELAY:       if (r_dcount == DCNT_W'(SAMPLE_DELAY - 1)) w_next = CAPTURE;
        CAPTURE:     if (r_xcount == XCNT_W'(SPRITE_W - 1)) w_next = STORE_LO;
        STORE_LO:    w_next = STORE_HI;
        STORE_HI:    w_next = (r_ycount == ROW_W'(ROWS - 1)) ? FINISH : WAIT_HSTART;
        FINISH:      w_next = IDLE;
        default:     w_next = IDLE;
      endcase
    end

    case (w_next)
      STORE_LO: begin
        w_wr_en   = 1'b1;
        w_wr_addr = w_addr;
        w_wr_data = w_inbits[DATA_W-1:0];
      end
      STORE_HI: begin
        w_wr_en     = 1'b1;
        w_addr.half = 1'b1;
        w_wr_addr   = w_addr;
        w_wr_data   = w_inbits[SPRITE_W-1:DATA_W];
      end
      FINISH:   w_done = 1'b1;
      default:  ;
    endcase
  end

  // Registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_en   <= 1'b0;
      r_done    <= 1'b0;
      r_busy    <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else begin
      r_wr_en   <= w_wr_en;
      r_done    <= w_done;
      r_busy    <= (w_next != IDLE);
      r_wr_addr <= w_wr_addr;
      r_wr_data <= w_wr_data;
    end
  end

  // Latched configuration, counters and shift register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_bm     <= '0;
      r_hm     <= 1'b0;
      r_vm     <= 1'b0;
      r_ycount <= '0;
      r_xcount <= '0;
      r_dcount <= '0;
      r_inbits <= '0;
    end else begin
      if (w_accept) begin
        r_bm     <= cap.bitmap_num;
        r_hm     <= cap.hmirror;
        r_vm     <= cap.vmirror;
        r_ycount <= '0;
      end
      case (r_state)
        WAIT_HSTART: begin
          if (cap.hstart) begin
            r_dcount <= '0;
            r_xcount <= '0;
          end
        end
        DELAY:    r_dcount <= r_dcount + DCNT_W'(1);
        CAPTURE: begin
          r_inbits <= w_inbits;
          r_xcount <= r_xcount + XCNT_W'(1);
        end
        STORE_HI: r_ycount <= r_ycount + ROW_W'(1);
        default:  ;
      endcase
    end
  end

  assign cap.wr_en   = r_wr_en;
  assign cap.done    = r_done;
  assign cap.busy    = r_busy;
  assign cap.wr_addr = r_wr_addr;
  assign cap.wr_data = r_wr_data;

endmodule

// File: tb/tb_sprite_capture.sv
// Bench for sprite_capture: three instances (SAMPLE_DELAY/ROWS = 1/16, 0/2, 3/16) share one
// stimulus stream; every write is compared against rows rebuilt from the recorded pixel stream.
module tb_sprite_capture;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sprite_capture_if ifa ();
  sprite_capture_if ifb ();
  sprite_capture_if ifc ();

  assign ifb.arm = ifa.arm;         assign ifc.arm = ifa.arm;
  assign ifb.bitmap_num = ifa.bitmap_num; assign ifc.bitmap_num = ifa.bitmap_num;
  assign ifb.hmirror = ifa.hmirror; assign ifc.hmirror = ifa.hmirror;
  assign ifb.vmirror = ifa.vmirror; assign ifc.vmirror = ifa.vmirror;
  assign ifb.abort = ifa.abort;     assign ifc.abort = ifa.abort;
  assign ifb.vstart = ifa.vstart;   assign ifc.vstart = ifa.vstart;
  assign ifb.hstart = ifa.hstart;   assign ifc.hstart = ifa.hstart;
  assign ifb.pixel = ifa.pixel;     assign ifc.pixel = ifa.pixel;

  sprite_capture #(.SAMPLE_DELAY(1), .ROWS(16)) u_dut_a (.clk(clk), .reset(rst_n), .cap(ifa));
  sprite_capture #(.SAMPLE_DELAY(0), .ROWS(2))  u_dut_b (.clk(clk), .reset(rst_n), .cap(ifb));
  sprite_capture #(.SAMPLE_DELAY(3), .ROWS(16)) u_dut_c (.clk(clk), .reset(rst_n), .cap(ifc));

  // Write/done logs (only this process writes them)
  logic [15:0] wqa[$];
  logic [15:0] wqb[$];
  logic [15:0] wqc[$];
  int done_a = 0;
  int done_b = 0;
  int done_c = 0;

  always @(negedge clk) begin
    if (ifa.wr_en === 1'b1) wqa.push_back({ifa.wr_addr, ifa.wr_data});
    if (ifb.wr_en === 1'b1) wqb.push_back({ifb.wr_addr, ifb.wr_data});
    if (ifc.wr_en === 1'b1) wqc.push_back({ifc.wr_addr, ifc.wr_data});
    if (ifa.done === 1'b1) done_a++;
    if (ifb.done === 1'b1) done_b++;
    if (ifc.done === 1'b1) done_c++;
  end

  int checks = 0;
  int errors = 0;
  int n = 0;
  logic stream [16384];
  int hs_q[$];
  logic [15:0] img [16];
  int wb [3];
  int db [3];

  function automatic int wq_size(input int d);
    case (d)
      0: return wqa.size();
      1: return wqb.size();
      default: return wqc.size();
    endcase
  endfunction

  function automatic logic [15:0] wq_at(input int d, input int i);
    if (i >= wq_size(d)) return 16'hxxxx;
    case (d)
      0: return wqa[i];
      1: return wqb[i];
      default: return wqc[i];
    endcase
  endfunction

  function automatic int done_cnt(input int d);
    case (d)
      0: return done_a;
      1: return done_b;
      default: return done_c;
    endcase
  endfunction

  function automatic logic busy_of(input int d);
    case (d)
      0: return ifa.busy;
      1: return ifb.busy;
      default: return ifc.busy;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic snapshot();
    for (int d = 0; d < 3; d++) begin
      wb[d] = wq_size(d);
      db[d] = done_cnt(d);
    end
  endtask

  // One clock: drive inputs at negedge, record what the DUT samples at the next posedge
  task automatic step(input logic pix, input logic hs, input logic vs, input logic a, input logic ab);
    @(negedge clk);
    ifa.pixel  = pix;
    ifa.hstart = hs;
    ifa.vstart = vs;
    ifa.arm    = a;
    ifa.abort  = ab;
    stream[n]  = pix;
    if (hs) hs_q.push_back(n);
    n++;
  endtask

  // One frame: vstart, then 16 lines of 32 pixels with hstart at the start of each line.
  // img[r] occupies line offsets 2..17 (the window the SAMPLE_DELAY=1 instance samples).
  task automatic frame(input bit rnd_fill, input bit poke, input int abort_line,
                       input int arm2_line, input int rst_line);
    logic pix;
    logic a;
    logic ab;
    bit   ab_prev;
    hs_q.delete();
    ab_prev = 1'b0;
    step(1'($urandom_range(0, 1)), 1'b0, 1'b1, 1'b0, 1'b0);
    for (int r = 0; r < 16; r++) begin
      for (int j = 0; j < 32; j++) begin
        if (j >= 2 && j < 18) pix = img[r][j-2];
        else if (rnd_fill)    pix = 1'($urandom_range(0, 1));
        else                  pix = (poke && r == 0 && j == 1);
        a  = 1'b0;
        ab = (abort_line == r && j == 28);
        if (arm2_line == r && j == 5) begin
          a = 1'b1;
          ifa.bitmap_num = 3'd5;
        end
        step(pix, (j == 0), 1'b0, a, ab);
        if (ab_prev) begin
          chk("busy_after_abort_a", 32'(ifa.busy), 32'd0);
          chk("busy_after_abort_c", 32'(ifc.busy), 32'd0);
        end
        ab_prev = ab;
        if (rst_line == r && j == 8) begin
          #2 rst_n = 1'b0;
          #1;
          chk("async_rst_busy_a", 32'(ifa.busy), 32'd0);
          chk("async_rst_wren_a", 32'(ifa.wr_en), 32'd0);
          chk("async_rst_busy_b", 32'(ifb.busy), 32'd0);
          chk("async_rst_busy_c", 32'(ifc.busy), 32'd0);
        end
        if (rst_line == r && j == 20) rst_n = 1'b1;
      end
    end
    repeat (4) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Reference: row r of a capture is the 16 samples starting sd+1 clocks after that
  // line's hstart; mirrored rows are bit-reversed, vmirrored rows land at 15-r.
  task automatic expect_dut(input int d, input int sd, input int nrows, input int ndone,
                            input logic [2:0] bm, input bit hm, input bit vm);
    logic [15:0] word;
    logic [15:0] rev;
    int row;
    chk($sformatf("nwrites_d%0d", d), 32'(wq_size(d) - wb[d]), 32'(2 * nrows));
    chk($sformatf("ndone_d%0d", d), 32'(done_cnt(d) - db[d]), 32'(ndone));
    chk($sformatf("busy_end_d%0d", d), 32'(busy_of(d)), 32'd0);
    for (int r = 0; r < nrows; r++) begin
      word = '0;
      for (int k = 0; k < 16; k++) word[k] = stream[hs_q[r] + sd + 1 + k];
      rev = {<<{word}};
      if (hm) word = rev;
      row = vm ? 15 - r : r;
      chk($sformatf("wr_d%0d_row%0d_lo", d, r), 32'(wq_at(d, wb[d] + 2*r)),
          32'({bm, 4'(row), 1'b0, word[7:0]}));
      chk($sformatf("wr_d%0d_row%0d_hi", d, r), 32'(wq_at(d, wb[d] + 2*r + 1)),
          32'({bm, 4'(row), 1'b1, word[15:8]}));
    end
  endtask

  task automatic arm_with(input logic [2:0] bm, input bit hm, input bit vm);
    ifa.bitmap_num = bm;
    ifa.hmirror    = hm;
    ifa.vmirror    = vm;
    snapshot();
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    logic [2:0] bm;
    rst_n = 1'b0;
    ifa.arm = 1'b0; ifa.bitmap_num = '0; ifa.hmirror = 1'b0; ifa.vmirror = 1'b0;
    ifa.abort = 1'b0; ifa.vstart = 1'b0; ifa.hstart = 1'b0; ifa.pixel = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_wr_en", 32'(ifa.wr_en), 32'd0);
    chk("rst_done", 32'(ifa.done), 32'd0);
    chk("rst_busy", 32'(ifa.busy), 32'd0);
    chk("rst_wr_addr", 32'(ifa.wr_addr), 32'd0);
    chk("rst_wr_data", 32'(ifa.wr_data), 32'd0);
    chk("rst_busy_b", 32'(ifb.busy), 32'd0);
    chk("rst_busy_c", 32'(ifc.busy), 32'd0);
    rst_n = 1'b1;
    repeat (3) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("idle_no_arm_busy", 32'(ifa.busy), 32'd0);
    chk("idle_no_arm_writes", 32'(wqa.size()), 32'd0);

    // Loopback of a bitmap with row 2 = 16'h0780 into slot 3
    for (int r = 0; r < 16; r++) img[r] = 16'($urandom());
    img[2] = 16'h0780;
    arm_with(3'd3, 1'b0, 1'b0);
    frame(1'b1, 1'b0, -1, -1, -1);
    chk("loop_row2_lo", 32'(wq_at(0, wb[0] + 4)), 32'h6480);
    chk("loop_row2_hi", 32'(wq_at(0, wb[0] + 5)), 32'h6507);
    for (int r = 0; r < 16; r++)
      chk($sformatf("loop_img_row%0d", r),
          32'({wq_at(0, wb[0] + 2*r + 1) & 16'h00ff, 8'h00} | (wq_at(0, wb[0] + 2*r) & 16'h00ff)),
          32'(img[r]));
    expect_dut(0, 1, 16, 1, 3'd3, 1'b0, 1'b0);
    expect_dut(1, 0, 2, 1, 3'd3, 1'b0, 1'b0);
    expect_dut(2, 3, 16, 1, 3'd3, 1'b0, 1'b0);

    // Random frame, both mirrors, random slot
    for (int r = 0; r < 16; r++) img[r] = 16'($urandom());
    bm = 3'($urandom_range(0, 7));
    arm_with(bm, 1'b1, 1'b1);
    frame(1'b1, 1'b0, -1, -1, -1);
    expect_dut(0, 1, 16, 1, bm, 1'b1, 1'b1);
    expect_dut(1, 0, 2, 1, bm, 1'b1, 1'b1);
    expect_dut(2, 3, 16, 1, bm, 1'b1, 1'b1);

    // Single pixel at sample 0 of row 0 with both mirrors
    for (int r = 0; r < 16; r++) img[r] = 16'h0000;
    img[0] = 16'h0001;
    arm_with(3'd2, 1'b1, 1'b1);
    frame(1'b0, 1'b0, -1, -1, -1);
    chk("mirror_row0_lo", 32'(wq_at(0, wb[0])), 32'h5E00);
    chk("mirror_row0_hi", 32'(wq_at(0, wb[0] + 1)), 32'h5F80);
    expect_dut(0, 1, 16, 1, 3'd2, 1'b1, 1'b1);
    expect_dut(1, 0, 2, 1, 3'd2, 1'b1, 1'b1);
    expect_dut(2, 3, 16, 1, 3'd2, 1'b1, 1'b1);

    // Pixel on the cycle right after hstart only
    img[0] = 16'h0000;
    arm_with(3'd0, 1'b0, 1'b0);
    frame(1'b0, 1'b1, -1, -1, -1);
    chk("delay0_lo", 32'(wq_at(1, wb[1])), 32'h0001);
    chk("delay1_lo", 32'(wq_at(0, wb[0])), 32'h0000);
    chk("delay3_lo", 32'(wq_at(2, wb[2])), 32'h0000);
    expect_dut(0, 1, 16, 1, 3'd0, 1'b0, 1'b0);
    expect_dut(1, 0, 2, 1, 3'd0, 1'b0, 1'b0);
    expect_dut(2, 3, 16, 1, 3'd0, 1'b0, 1'b0);

    // Abort after row 5 has been stored
    for (int r = 0; r < 16; r++) img[r] = 16'($urandom());
    arm_with(3'd6, 1'b0, 1'b1);
    frame(1'b1, 1'b0, 5, -1, -1);
    expect_dut(0, 1, 6, 0, 3'd6, 1'b0, 1'b1);
    expect_dut(1, 0, 2, 1, 3'd6, 1'b0, 1'b1);
    expect_dut(2, 3, 6, 0, 3'd6, 1'b0, 1'b1);

    // Fresh arm after abort; second arm with slot 5 while busy is ignored
    for (int r = 0; r < 16; r++) img[r] = 16'($urandom());
    arm_with(3'd1, 1'b0, 1'b0);
    frame(1'b1, 1'b0, -1, 0, -1);
    expect_dut(0, 1, 16, 1, 3'd1, 1'b0, 1'b0);
    expect_dut(1, 0, 2, 1, 3'd1, 1'b0, 1'b0);
    expect_dut(2, 3, 16, 1, 3'd1, 1'b0, 1'b0);

    // Asynchronous reset in the middle of row 1; nothing more until a new arm
    for (int r = 0; r < 16; r++) img[r] = 16'($urandom());
    arm_with(3'd4, 1'b1, 1'b0);
    frame(1'b1, 1'b0, -1, -1, 1);
    expect_dut(0, 1, 1, 0, 3'd4, 1'b1, 1'b0);
    expect_dut(1, 0, 1, 0, 3'd4, 1'b1, 1'b0);
    expect_dut(2, 3, 1, 0, 3'd4, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
